mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS, default 10, meaning word-address width (2^WORDS words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning memory word width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk_i input 1 (pos-edge, sole clock); reset_i input 1 (async, active-high).
REQ-004 SHALL have the following instruction-port signals:
- if_req_i input 1: fetch request.
- if_addr_i input WORDS+2: byte address.
- if_ack_o output 1: fetch done.
- if_data_o output DATA_WIDTH: fetched word.
REQ-005 SHALL have the following data-port signals:
- d_req_i input 1: request.
- d_we_i input 1: 1=store.
- d_size_i input 2: 00 byte, 01 half, 10 word.
- d_addr_i input WORDS+2: byte address.
- d_wdata_i input DATA_WIDTH: store data, right-justified.
- d_ack_o output 1: done.
- d_err_o output 1: misaligned.
- d_rdata_o output DATA_WIDTH: raw loaded word.
REQ-006 SHALL have the following memory-side signals:
- mem_addr_o output WORDS: word address.
- mem_data_o output DATA_WIDTH: write data.
- mem_wr_o output 1: write strobe, active-low.
- mem_rd_o output 1: read strobe, active-low.
- mem_data_i input DATA_WIDTH: memory output, registered by the memory on negedge.

Function
REQ-007 SHALL implement FSM states IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
REQ-008 SHALL sample requests only in IDLE; requesters hold req/addr/data stable until their ack.
REQ-009 SHALL, in IDLE with a grant:
- IF read or data load -> RD.
- Word store -> WR.
- Byte/half store -> RMW_RD.
- Misaligned data request (half with addr[0]=1; word with addr[1:0]!=0) -> DONE with d_err_o, no memory strobe.
REQ-010 SHALL drive mem_rd_o=0 only in RD/RMW_RD and mem_wr_o=0 only in WR/RMW_WR, one cycle each; mem_addr_o/mem_data_o registered and stable for the whole strobe cycle.
REQ-011 SHALL capture mem_data_i at the posedge ending RD into the granted port's data register, and at the posedge ending RMW_RD into a merge buffer.
REQ-012 SHALL merge in RMW_WR, little-endian:
- Byte -> lane addr[1:0], bits 8*addr[1:0]+7:8*addr[1:0] = d_wdata_i[7:0].
- Half -> lane addr[1], 16 bits = d_wdata_i[15:0].
- Other bits from the buffer.
REQ-013 SHALL pulse the granted port's ack for exactly one cycle in DONE, with data/err valid in that cycle; DONE -> IDLE unconditionally.
REQ-014 SHALL have the following latencies from the req-sampling edge to the ack cycle:
- Read / word store: 2 cycles.
- Sub-word store: 3 cycles.
- Misaligned: 1 cycle.
REQ-015 SHALL treat d_size_i=11 as word size.
REQ-016 SHALL hold if_data_o/d_rdata_o until that port's next read completes; d_err_o is 0 outside DONE.
REQ-017 SHALL never assert mem_rd_o and mem_wr_o low simultaneously, nor both acks in one cycle.

Reset
REQ-018 SHALL, on reset_i high (any state, including mid-RMW):
- Go immediately to IDLE.
- Drive mem_rd_o=1 and mem_wr_o=1.
- Drive acks=0, d_err_o=0, data registers=0, mem_addr_o=0, mem_data_o=0.
- Drop any in-flight request without an ack.
- Reset the priority pointer to favour IF.

Configuration
REQ-019 SHALL, with ARB_ROUND_ROBIN_EN defined, resolve simultaneous requests round-robin: the port not granted last wins, and the pointer updates on every grant.
REQ-020 SHALL, without ARB_ROUND_ROBIN_EN, give the data port fixed priority over the IF port.

Structure
REQ-021 SHALL place the state enum, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the port-id type in package mem_arbiter_pkg.
REQ-022 SHALL implement lane merge and alignment check in combinational sub-module mem_lane_merge (inputs: word, wdata, size, addr[1:0]; outputs: merged word, misaligned).

Verification
REQ-023 SHALL cover IF read of byte 0x010 with mem[4]=0x0000000A -> mem_rd_o low one cycle, addr 4; if_ack_o 2 cycles after sampling, if_data_o=0x0000000A.
REQ-024 SHALL cover sb d_addr_i=0x0059, d_wdata_i=0x000000EE, mem[22]=0x00E100A3 -> RMW_RD then RMW_WR; mem[22]=0x00E1EEA3; d_ack_o at cycle 3.
REQ-025 SHALL cover sh d_addr_i=0x0053 -> d_ack_o and d_err_o high 1 cycle after sampling; mem_wr_o/mem_rd_o never low; memory unchanged.
REQ-026 SHALL cover if_req_i and d_req_i (lw 0x050) held high together for 4 transactions:
- With ARB_ROUND_ROBIN_EN: grants IF, D, IF, D.
- Without: D completes first, then IF.
REQ-027 SHALL cover reset_i asserted during RMW_WR of sh 0x0058 -> strobes high immediately, state IDLE, no ack, the merged write is not committed if reset precedes the negedge.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, access sizes, port ids.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian sub-word store merge and data-port alignment check (combinational).
module mem_lane_merge
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            size,
  input  logic [1:0]            addr,
  output logic [DATA_WIDTH-1:0] merged,
  output logic                  misaligned
);

  always_comb begin
    merged     = word;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: merged[{addr, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        misaligned                       = addr[0];
      end
      // 2'b11 is treated as a word access
      default: begin
        merged     = wdata;
        misaligned = |addr;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-ported memory.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default gives the data port priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  if_req_i,
  input  logic [WORDS+1:0]      if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_data_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic [WORDS+1:0]      d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wr_o,
  output logic                  mem_rd_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  state_t                state_q, state_d;
  port_t                 gnt_q, gnt_d, pick;
  logic                  err_q;
  logic                  grant;
  logic [DATA_WIDTH-1:0] merged;
  logic                  misaligned;
  logic                  if_addr_unused;

  assign if_addr_unused = |if_addr_i[1:0];
  assign grant          = (state_q == IDLE) && (if_req_i || d_req_i);

  mem_lane_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .word       (mem_data_i),
    .wdata      (d_wdata_i),
    .size       (d_size_i),
    .addr       (d_addr_i[1:0]),
    .merged     (merged),
    .misaligned (misaligned)
  );

`ifdef ARB_ROUND_ROBIN_EN
  port_t last_q;

  // Reset value of PORT_D makes the first contested grant go to IF
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)    last_q <= PORT_D;
    else if (grant) last_q <= gnt_d;
  end
`endif

  always_comb begin
    pick = d_req_i ? PORT_D : PORT_IF;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req_i && d_req_i) pick = (last_q == PORT_IF) ? PORT_D : PORT_IF;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: if (grant) begin
        gnt_d = pick;
        if (pick == PORT_D && misaligned)            state_d = DONE;
        else if (pick == PORT_IF || !d_we_i)         state_d = RD;
        else if (d_size_i == SZ_BYTE || d_size_i == SZ_HALF) state_d = RMW_RD;
        else                                         state_d = WR;
      end
      RD, WR, RMW_WR: state_d = DONE;
      RMW_RD:         state_d = RMW_WR;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      gnt_q      <= PORT_IF;
      err_q      <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      if_data_o  <= '0;
      d_rdata_o  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      if (grant) begin
        err_q      <= (state_d == DONE);
        mem_addr_o <= (gnt_d == PORT_D) ? d_addr_i[WORDS+1:2] : if_addr_i[WORDS+1:2];
        if (state_d == WR) mem_data_o <= merged;
      end
      if (state_q == RD) begin
        if (gnt_q == PORT_IF) if_data_o <= mem_data_i;
        else                  d_rdata_o <= mem_data_i;
      end
      // mem_data_o doubles as the merge buffer: the merged word is latched here so
      // it is already stable for the whole RMW_WR strobe cycle
      if (state_q == RMW_RD) mem_data_o <= merged;
    end
  end

  assign mem_rd_o = !((state_q == RD) || (state_q == RMW_RD));
  assign mem_wr_o = !((state_q == WR) || (state_q == RMW_WR));
  assign if_ack_o = (state_q == DONE) && (gnt_q == PORT_IF);
  assign d_ack_o  = (state_q == DONE) && (gnt_q == PORT_D);
  assign d_err_o  = d_ack_o && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases, reset abort, arbitration order,
// then random traffic against a transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int WORDS = 10;
  localparam int DW    = 32;
  localparam int AW    = WORDS + 2;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_ack_o;
  logic [DW-1:0] if_data_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [1:0]    d_size_i = SZ_WORD;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic          d_ack_o;
  logic          d_err_o;
  logic [DW-1:0] d_rdata_o;
  logic [WORDS-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_wr_o;
  logic          mem_rd_o;
  logic [DW-1:0] mem_data_i = '0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.WORDS(WORDS), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_wr_o(mem_wr_o),
    .mem_rd_o(mem_rd_o), .mem_data_i(mem_data_i)
  );

  // Memory device: acts on active-low strobes at the falling edge
  logic [DW-1:0] mem     [0:(1<<WORDS)-1];
  logic [DW-1:0] ref_mem [0:(1<<WORDS)-1];

  always @(negedge clk_i) begin
    if (!mem_rd_o) mem_data_i = mem[mem_addr_o];
    if (!mem_wr_o) mem[mem_addr_o] = mem_data_o;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_d  = '0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misaligned_ref(input logic [1:0] size, input logic [AW-1:0] a);
    return (int'(a) % size_bytes(size)) != 0;
  endfunction

  function automatic logic [DW-1:0] store_ref(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                                input logic [1:0] size, input logic [AW-1:0] a);
    int unsigned   nb = size_bytes(size);
    int unsigned   sh = 8 * (int'(a) % 4);
    logic [DW-1:0] mask;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic run_txn(input bit is_d, input bit we, input logic [1:0] size,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int unsigned widx = int'(a) / 4;
    bit err   = is_d && misaligned_ref(size, a);
    bit store = is_d && we && !err;
    bit load  = !err && !(is_d && we);
    bit sub   = store && (size_bytes(size) < 4);
    int exp_lat = err ? 1 : (sub ? 3 : 2);
    int rd_n = 0, wr_n = 0, lat = 0;
    bit acked = 0, got_d = 0, got_err = 0, overlap = 0, dual = 0, stray_err = 0;
    logic [WORDS-1:0] rd_addr = '0, wr_addr = '0;
    logic [DW-1:0] got_if = '0, got_dr = '0;

    @(posedge clk_i); #1;
    if (is_d) begin
      d_req_i = 1'b1; d_we_i = we; d_size_i = size; d_addr_i = a; d_wdata_i = wd;
    end else begin
      if_req_i = 1'b1; if_addr_i = a;
    end
    @(posedge clk_i);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      if (!mem_rd_o) begin rd_n++; rd_addr = mem_addr_o; end
      if (!mem_wr_o) begin wr_n++; wr_addr = mem_addr_o; end
      if (!mem_rd_o && !mem_wr_o) overlap = 1;
      if (if_ack_o && d_ack_o) dual = 1;
      if (d_err_o && !d_ack_o) stray_err = 1;
      if (if_ack_o || d_ack_o) begin
        acked = 1; lat = c; got_d = d_ack_o; got_err = d_err_o;
        got_if = if_data_o; got_dr = d_rdata_o;
        break;
      end
    end

    if (store) ref_mem[widx] = store_ref(ref_mem[widx], wd, size, a);
    if (load) begin
      if (is_d) last_d = ref_mem[widx];
      else      last_if = ref_mem[widx];
    end

    check("ack_seen", acked, 1);
    check("latency", lat, exp_lat);
    check("ack_port", got_d, is_d);
    check("err", got_err, err);
    check("err_outside_done", stray_err, 0);
    check("if_data", got_if, last_if);
    check("d_rdata", got_dr, last_d);
    check("rd_strobes", rd_n, (load || sub) ? 1 : 0);
    check("wr_strobes", wr_n, store ? 1 : 0);
    if (rd_n > 0) check("rd_addr", rd_addr, widx);
    if (wr_n > 0) check("wr_addr", wr_addr, widx);
    check("strobe_overlap", overlap, 0);
    check("dual_ack", dual, 0);

    @(posedge clk_i); #1;
    if_req_i = 1'b0; d_req_i = 1'b0;
    check("mem_word", mem[widx], ref_mem[widx]);
  endtask

  // Both ports request continuously; each drops its request after two acks
  task automatic arb_test();
    int il = 2, dl = 2;
    bit last_d_win = 1;
    bit exp_order[$];
    bit got_order[$];
    for (int k = 0; k < 4; k++) begin
      bit win;
      if (il > 0 && dl > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = !last_d_win;
`else
        win = 1;
`endif
      end else begin
        win = (dl > 0);
      end
      exp_order.push_back(win);
      last_d_win = win;
      if (win) dl--; else il--;
    end

    mem[4] = 32'h1111_0004;  ref_mem[4] = 32'h1111_0004;
    mem[20] = 32'h2222_0014; ref_mem[20] = 32'h2222_0014;
    il = 2; dl = 2;
    @(posedge clk_i); #1;
    if_req_i = 1'b1; if_addr_i = 12'h010;
    d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = SZ_WORD; d_addr_i = 12'h050;
    for (int c = 0; c < 40 && (il > 0 || dl > 0); c++) begin
      @(negedge clk_i);
      if (if_ack_o && d_ack_o) check("arb_dual_ack", 1, 0);
      if (if_ack_o) begin
        got_order.push_back(0); il--;
        check("arb_if_data", if_data_o, ref_mem[4]);
      end
      if (d_ack_o) begin
        got_order.push_back(1); dl--;
        check("arb_d_data", d_rdata_o, ref_mem[20]);
      end
      @(posedge clk_i); #1;
      if (il <= 0) if_req_i = 1'b0;
      if (dl <= 0) d_req_i = 1'b0;
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    last_if = ref_mem[4]; last_d = ref_mem[20];
    check("arb_count", got_order.size(), 4);
    for (int k = 0; k < 4 && k < got_order.size(); k++)
      check($sformatf("arb_grant%0d", k), got_order[k], exp_order[k]);
  endtask

  bit            r_is_d, r_we;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wd;
  bit            seen_ack;

  initial begin
    for (int i = 0; i < (1 << WORDS); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    repeat (2) @(negedge clk_i);
    check("rst_rd", mem_rd_o, 1);
    check("rst_wr", mem_wr_o, 1);
    check("rst_if_ack", if_ack_o, 0);
    check("rst_d_ack", d_ack_o, 0);
    check("rst_err", d_err_o, 0);
    check("rst_if_data", if_data_o, 0);
    check("rst_d_rdata", d_rdata_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_data", mem_data_o, 0);
    @(posedge clk_i); #1; reset_i = 1'b0;

    mem[4] = 32'h0000_000A; ref_mem[4] = 32'h0000_000A;
    run_txn(0, 0, SZ_WORD, 12'h010, '0);
    check("if_read_val", if_data_o, 32'h0000_000A);

    mem[22] = 32'h00E1_00A3; ref_mem[22] = 32'h00E1_00A3;
    run_txn(1, 1, SZ_BYTE, 12'h059, 32'h0000_00EE);
    check("sb_merge", mem[22], 32'h00E1_EEA3);

    run_txn(1, 1, SZ_HALF, 12'h053, 32'h0000_1234);
    check("sh_misaligned_mem", mem[20], ref_mem[20]);
    run_txn(1, 1, SZ_HALF, 12'h05A, 32'h0000_BEEF);
    run_txn(1, 0, 2'b11, 12'h062, '0);
    run_txn(1, 1, 2'b11, 12'h064, 32'hDEAD_BEEF);
    run_txn(1, 0, SZ_WORD, 12'h064, '0);

    // Reset during RMW_WR of sh 0x058: no write, no ack, all state cleared
    mem[22] = 32'hCAFE_F00D; ref_mem[22] = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = SZ_HALF; d_addr_i = 12'h058; d_wdata_i = 32'h5555;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    #1;
    check("rmw_rst_wr", mem_wr_o, 1);
    check("rmw_rst_rd", mem_rd_o, 1);
    check("rmw_rst_ack", d_ack_o, 0);
    d_req_i = 1'b0;
    @(negedge clk_i);
    check("rmw_rst_mem", mem[22], ref_mem[22]);
    check("rmw_rst_d_rdata", d_rdata_o, 0);
    check("rmw_rst_if_data", if_data_o, 0);
    check("rmw_rst_mem_addr", mem_addr_o, 0);
    check("rmw_rst_mem_data", mem_data_o, 0);
    last_if = '0; last_d = '0;
    @(posedge clk_i); #1 reset_i = 1'b0;
    seen_ack = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (if_ack_o || d_ack_o || !mem_wr_o || !mem_rd_o) seen_ack = 1;
    end
    check("rmw_rst_quiet", seen_ack, 0);

    arb_test();

    for (int i = 0; i < 80; i++) begin
      r_is_d = 1'($urandom_range(0, 1));
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = AW'($urandom_range(0, 127));
      r_wd   = $urandom;
      run_txn(r_is_d, r_we, r_size, r_addr, r_wd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
